// File: rtl/banco_registradores_sb_if.sv
// Bus interface for banco_registradores_sb: decode-side read/issue signals and
// writeback-side write signals, grouped so the register file takes one bundle.
// The master modport is the pipeline side, the slave modport is the register file.
interface banco_registradores_sb_if #(
    parameter int WIDTH  = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]       rd_busy;
    logic                    we;
    logic [AW-1:0]           wr_addr;
    logic [WIDTH-1:0]        wr_data;
    logic                    iss_valid;
    logic [AW-1:0]           iss_addr;
    logic [AW:0]             busy_cnt;

    modport master (
        output rd_addr, we, wr_addr, wr_data, iss_valid, iss_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, we, wr_addr, wr_data, iss_valid, iss_addr,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/banco_registradores_sb.sv
// banco_registradores_sb: parametrised MIPS register file with NUM_RD
// combinational read ports, one synchronous write port and a per-register
// busy scoreboard (set at issue, cleared at writeback, issue wins a tie).
// busy_cnt is the registered popcount of the busy bits.
// Optional feature macro: REGFILE_BYPASS_EN enables same-cycle write-to-read
// forwarding of data (busy forwarded as 0 unless the same register is being
// re-issued this cycle).
module banco_registradores_sb #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    banco_registradores_sb_if.slave bus
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;

    // Register 0 is read-only zero when ZERO_REG is set, so writes and issues
    // aimed at it are dropped before they reach the array or scoreboard.
    logic wr_en;
    logic iss_en;

    // Qualify write and issue against the hardwired-zero register.
    always_comb begin
        wr_en  = bus.we;
        iss_en = bus.iss_valid;
        if ((ZERO_REG != 0) && (bus.wr_addr == '0)) begin
            wr_en = 1'b0;
        end
        if ((ZERO_REG != 0) && (bus.iss_addr == '0)) begin
            iss_en = 1'b0;
        end
    end

    // Next array contents: only the addressed register changes on a write.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // Next scoreboard: clear applied first so a same-edge issue overrides it
    // (the newer producer owns the register).
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (wr_en && (bus.wr_addr == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
            if (iss_en && (bus.iss_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    // Popcount of the next busy vector so the count moves on the same edge.
    always_comb begin
        busy_cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    // Array, scoreboard and count state; async reset clears everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Combinational read ports with optional forwarding and zero-register override.
    always_comb begin
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic             busy;
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            addr = bus.rd_addr[k*AW +: AW];
            data = regs_q[addr];
            busy = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (bus.wr_addr == addr)) begin
                data = bus.wr_data;
                busy = iss_en && (bus.iss_addr == bus.wr_addr);
            end
`endif
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
                busy = 1'b0;
            end
            bus.rd_data[k*WIDTH +: WIDTH] = data;
            bus.rd_busy[k]                = busy;
        end
    end

    assign bus.busy_cnt = busy_cnt_q;

endmodule
